// File: rtl/sr_result_capture.sv
// Result capture for the SR_full_top pipeline: records each frame result on the rising edge of done
// into a first-word-fall-through FIFO, tracking lost frames and a start-gated stall watchdog.
module sr_result_capture #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     done,
  // 'final' is a reserved word, so the last-frame marker is named final_frame
  input  logic                     final_frame,
  input  logic [9:0]               out0,
  input  logic [9:0]               out1,
  input  logic [3:0]               classification_result,
  input  logic [23:0]              regression_result,
  output logic [63:0]              rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              drop_count,
  output logic                     timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [19:0] WD_LIMIT   = 20'(TIMEOUT);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          done_d;
  logic [14:0]   frame_idx;
  logic [19:0]   watchdog;
  logic          capture;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [63:0]   record;

  assign capture  = done & ~done_d;
  assign full     = (count == FULL_LEVEL);
  assign rd_valid = (count != '0);
  assign pop      = rd_valid & rd_ready & ~clear;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the capture.
  assign push     = capture & ~clear & (~full | pop);
  assign drop     = capture & ~clear & full & ~pop;
  assign record   = {final_frame, frame_idx, classification_result, regression_result, out0, out1};
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
  assign level    = count;

  // NOTE: the storage array is deliberately not reset; rd_data is masked by rd_valid, so stale
  // contents are never visible and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= record;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      done_d     <= 1'b0;
      frame_idx  <= '0;
      watchdog   <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      timeout    <= 1'b0;
    end else begin
      // done_d keeps tracking during clear so a done held across clear is not seen as a new edge
      done_d <= done;
      if (clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        frame_idx  <= '0;
        watchdog   <= '0;
        overflow   <= 1'b0;
        drop_count <= '0;
        timeout    <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        case ({push, pop})
          2'b10:   count <= count + LVL_ONE;
          2'b01:   count <= count - LVL_ONE;
          default: count <= count;
        endcase

        if (capture) frame_idx <= final_frame ? 15'd0 : frame_idx + 15'd1;

        if (drop) begin
          overflow <= 1'b1;
          if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end

        if (!start || capture) begin
          watchdog <= '0;
        end else if (watchdog != WD_LIMIT) begin
          watchdog <= watchdog + 20'd1;
          if (watchdog == WD_LIMIT - 20'd1) timeout <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sr_result_capture.sv
// Bench for sr_result_capture: directed scenarios plus randomized traffic against a queue-based
// model of the capture FIFO, frame numbering, drop accounting and watchdog.
module tb_sr_result_capture;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        done = 1'b0;
  logic        final_frame = 1'b0;
  logic [9:0]  out0 = '0;
  logic [9:0]  out1 = '0;
  logic [3:0]  cls = '0;
  logic [23:0] regr = '0;
  logic        rd_ready = 1'b0;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_count;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  sr_result_capture #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start), .done(done),
    .final_frame(final_frame), .out0(out0), .out1(out1),
    .classification_result(cls), .regression_result(regr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .level(level),
    .overflow(overflow), .drop_count(drop_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: records in a queue, counters as plain integers.
  logic [63:0] m_q[$];
  int          m_idx;
  int          m_drops;
  int          m_wd;
  bit          m_ovf;
  bit          m_to;
  bit          m_prev_done;

  function automatic logic [63:0] mk_rec(logic fin, logic [14:0] idx, logic [3:0] c,
                                         logic [23:0] r, logic [9:0] a, logic [9:0] b);
    return {fin, idx, c, r, a, b};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_idx = 0; m_drops = 0; m_wd = 0; m_ovf = 0; m_to = 0; m_prev_done = 0;
  endtask

  task automatic model_edge();
    bit cap;
    if (!reset) begin
      model_reset();
      return;
    end
    cap = done && !m_prev_done;
    m_prev_done = done;
    if (clear) begin
      m_q.delete();
      m_idx = 0; m_drops = 0; m_wd = 0; m_ovf = 0; m_to = 0;
      return;
    end
    if (m_q.size() > 0 && rd_ready) void'(m_q.pop_front());
    if (cap) begin
      if (m_q.size() < DEPTH) m_q.push_back(mk_rec(final_frame, 15'(m_idx), cls, regr, out0, out1));
      else begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end
      m_idx = final_frame ? 0 : (m_idx + 1) % 32768;
    end
    if (!start || cap) m_wd = 0;
    else if (m_wd < TIMEOUT) begin
      m_wd++;
      if (m_wd == TIMEOUT) m_to = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic pulse();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({rd_valid, level, overflow, drop_count, timeout} !== '0 || rd_data !== 64'h0) begin
      bad++;
      $display("FAIL reset_state: got valid=%0b level=%0d ovf=%0b drops=%0d to=%0b data=%h want all zero",
               rd_valid, level, overflow, drop_count, timeout, rd_data);
    end
    reset = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_single_frame();
    out0 = 10'h155; out1 = 10'h2AA; cls = 4'd7; regr = 24'd1280; final_frame = 1'b0; rd_ready = 1'b0;
    done = 1'b1;
    tick();
    total++;
    if (rd_valid !== 1'b1 || level !== 5'd1 || rd_data !== 64'h0000_7000_5005_56AA) begin
      bad++;
      $display("FAIL single_frame: got valid=%0b level=%0d data=%h want 1 1 0000700050055_6aa",
               rd_valid, level, rd_data);
    end
    done = 1'b0;
    out0 = '0; out1 = '0; cls = '0; regr = '0;
    repeat (3) tick();
    total++;
    if (rd_data !== 64'h0000_7000_5005_56AA) begin
      bad++;
      $display("FAIL head_stable: got %h want 00007000500556aa", rd_data);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    total++;
    if (rd_valid !== 1'b0 || level !== 5'd0) begin
      bad++;
      $display("FAIL single_pop: got valid=%0b level=%0d want 0 0", rd_valid, level);
    end
  endtask

  task automatic test_held_done();
    do_clear();
    done = 1'b1;
    repeat (10) tick();
    done = 1'b0;
    tick();
    total++;
    if (level !== 5'd1) begin
      bad++;
      $display("FAIL held_done: got level=%0d want 1", level);
    end
    pulse();
    pulse();
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rd_valid !== 1'b1 || rd_data[62:48] !== 15'(i)) begin
        bad++;
        $display("FAIL pulse_idx: got valid=%0b idx=%0d want 1 %0d", rd_valid, rd_data[62:48], i);
      end
      tick();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_clear();
    repeat (19) pulse();
    total++;
    if (level !== 5'd16 || overflow !== 1'b1 || drop_count !== 16'd3) begin
      bad++;
      $display("FAIL overflow: got level=%0d ovf=%0b drops=%0d want 16 1 3", level, overflow, drop_count);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (rd_valid !== 1'b1 || rd_data[62:48] !== 15'(i)) begin
        bad++;
        $display("FAIL drain_order: got valid=%0b idx=%0d want 1 %0d", rd_valid, rd_data[62:48], i);
      end
      tick();
    end
    rd_ready = 1'b0;
    total++;
    if (rd_valid !== 1'b0 || rd_data !== 64'h0) begin
      bad++;
      $display("FAIL drained_empty: got valid=%0b data=%h want 0 0", rd_valid, rd_data);
    end
    pulse();
    total++;
    if (rd_data[62:48] !== 15'd19) begin
      bad++;
      $display("FAIL idx_after_drop: got %0d want 19", rd_data[62:48]);
    end
  endtask

  task automatic test_full_pop_capture();
    do_clear();
    repeat (16) pulse();
    done = 1'b1; rd_ready = 1'b1;
    tick();
    done = 1'b0; rd_ready = 1'b0;
    total++;
    if (level !== 5'd16 || drop_count !== 16'd0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL full_pop_capture: got level=%0d drops=%0d ovf=%0b want 16 0 0",
               level, drop_count, overflow);
    end
    tick();
    rd_ready = 1'b1;
    repeat (16) tick();
    rd_ready = 1'b0;
    final_frame = 1'b1;
    pulse();
    final_frame = 1'b0;
    total++;
    if (rd_data[63] !== 1'b1 || rd_data[62:48] !== 15'd17) begin
      bad++;
      $display("FAIL final_rec: got final=%0b idx=%0d want 1 17", rd_data[63], rd_data[62:48]);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    pulse();
    total++;
    if (rd_data[63] !== 1'b0 || rd_data[62:48] !== 15'd0) begin
      bad++;
      $display("FAIL after_final: got final=%0b idx=%0d want 0 0", rd_data[63], rd_data[62:48]);
    end
  endtask

  task automatic test_empty_pop_capture();
    do_clear();
    rd_ready = 1'b1; done = 1'b1;
    tick();
    done = 1'b0; rd_ready = 1'b0;
    total++;
    if (rd_valid !== 1'b1 || level !== 5'd1 || rd_data[62:48] !== 15'd0) begin
      bad++;
      $display("FAIL empty_pop_capture: got valid=%0b level=%0d idx=%0d want 1 1 0",
               rd_valid, level, rd_data[62:48]);
    end
    tick();
  endtask

  task automatic test_clear_dominates();
    do_clear();
    pulse();
    pulse();
    clear = 1'b1; done = 1'b1; rd_ready = 1'b1;
    tick();
    clear = 1'b0; done = 1'b0; rd_ready = 1'b0;
    total++;
    if (rd_valid !== 1'b0 || level !== 5'd0) begin
      bad++;
      $display("FAIL clear_dominates: got valid=%0b level=%0d want 0 0", rd_valid, level);
    end
    tick();
    pulse();
    total++;
    if (level !== 5'd1 || rd_data[62:48] !== 15'd0) begin
      bad++;
      $display("FAIL clear_idx: got level=%0d idx=%0d want 1 0", level, rd_data[62:48]);
    end
  endtask

  task automatic test_timeout();
    do_clear();
    start = 1'b1;
    repeat (4000) tick();
    pulse();
    repeat (4000) tick();
    total++;
    if (timeout !== 1'b0) begin
      bad++;
      $display("FAIL wd_capture_reset: got timeout=%0b want 0", timeout);
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    repeat (TIMEOUT - 1) tick();
    total++;
    if (timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early: got %0b want 0", timeout);
    end
    tick();
    total++;
    if (timeout !== 1'b1) begin
      bad++;
      $display("FAIL timeout_set: got %0b want 1", timeout);
    end
    repeat (10) tick();
    pulse();
    total++;
    if (timeout !== 1'b1 || level !== 5'd2) begin
      bad++;
      $display("FAIL timeout_sticky: got to=%0b level=%0d want 1 2", timeout, level);
    end
    do_clear();
    start = 1'b0;
    total++;
    if (timeout !== 1'b0) begin
      bad++;
      $display("FAIL timeout_clear: got %0b want 0", timeout);
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    repeat (5) pulse();
    done = 1'b1;
    tick();
    done = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (rd_valid !== 1'b0 || level !== 5'd0 || rd_data !== 64'h0) begin
      bad++;
      $display("FAIL async_reset: got valid=%0b level=%0d data=%h want 0 0 0", rd_valid, level, rd_data);
    end
    tick();
    reset = 1'b1;
    tick();
    pulse();
    total++;
    if (level !== 5'd1 || rd_data[62:48] !== 15'd0) begin
      bad++;
      $display("FAIL resume_idx: got level=%0d idx=%0d want 1 0", level, rd_data[62:48]);
    end
  endtask

  task automatic test_random();
    logic [63:0] exp_data;
    do_clear();
    for (int n = 0; n < 3000; n++) begin
      done        = ($urandom_range(0, 9) < 4);
      rd_ready    = ($urandom_range(0, 9) < 3);
      clear       = ($urandom_range(0, 199) == 0);
      start       = ($urandom_range(0, 19) != 0);
      final_frame = ($urandom_range(0, 7) == 0);
      out0 = 10'($urandom); out1 = 10'($urandom);
      cls  = 4'($urandom);  regr = 24'($urandom);
      tick();
      exp_data = (m_q.size() > 0) ? m_q[0] : 64'h0;
      total++;
      if (rd_valid !== (m_q.size() > 0) || level !== 5'(m_q.size()) || rd_data !== exp_data ||
          overflow !== m_ovf || drop_count !== 16'(m_drops) || timeout !== m_to) begin
        bad++;
        $display("FAIL random_cycle%0d: got v=%0b l=%0d d=%h o=%0b dc=%0d t=%0b want v=%0b l=%0d d=%h o=%0b dc=%0d t=%0b",
                 n, rd_valid, level, rd_data, overflow, drop_count, timeout,
                 m_q.size() > 0, m_q.size(), exp_data, m_ovf, m_drops, m_to);
      end
    end
    clear = 1'b0; done = 1'b0; rd_ready = 1'b0; start = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_frame();
    test_held_done();
    test_overflow();
    test_full_pop_capture();
    test_empty_pop_capture();
    test_clear_dominates();
    test_timeout();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
